ctx_mem_arbiter: RTL and testbench
==================================

# ctx_mem_arbiter

Shares one OBI data-memory port between the cv32e40p core data interface and the RTOS unit's context-memory traffic: context-save writes and context-restore read requests. Sits between the core/RTOS-unit pair and the data memory. It locks a granted requester until the memory accepts the request, tracks outstanding transactions in an owner FIFO, and routes each response back to its originator. An optional starvation counter bounds how long context traffic can be blocked by the core.

## Interface
- MAX_OUTSTANDING, 2: depth of the owner FIFO, which is also the maximum number of granted-but-unanswered transactions (1..8).
- STARVE_LIMIT, 8: number of consecutive cycles pending context traffic may lose arbitration before it takes priority (1..255).
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- data_req_i / data_we_i / data_be_i[3:0] / data_addr_i[31:0] / data_wdata_i[31:0]  in  core OBI request
- data_gnt_o / data_rvalid_o  out  1  core OBI grant / response valid
- data_rdata_o  out  32  core read data
- ctx_wr_valid_i  in  1; ctx_wr_addr_i / ctx_wr_data_i  in  32  context-save write
- ctx_wr_ready_o  out  1  write accepted this cycle
- ctx_rd_rq_valid_i  in  1; ctx_rd_rq_addr_i  in  32  context-restore read request
- ctx_rd_rq_ready_o  out  1  read request accepted this cycle
- ctx_rd_resp_valid_o  out  1; ctx_rd_data_o  out  32  context read response
- mem_req_o / mem_we_o  out  1; mem_be_o  out  4; mem_addr_o / mem_wdata_o  out  32  downstream OBI request
- mem_gnt_i / mem_rvalid_i  in  1; mem_rdata_i  in  32  downstream OBI grant / response
- err_o  out  1  sticky protocol error

## Operation
- Sources: CORE, CTX_WR, CTX_RD. Context writes use we=1, be=4'hF. Context reads use we=0, be=4'hF.
- FSM states: IDLE, HOLD_CORE, HOLD_WR, HOLD_RD.
  - In IDLE, the winning source drives mem_* combinationally.
  - If mem_gnt_i=0 that cycle, move to the matching HOLD state. The mux stays locked to that source until mem_gnt_i=1, then return to IDLE.
  - A HOLD state never switches source. The requester must keep its request stable, per the OBI and valid/ready rules.
- Priority in IDLE: CORE > CTX_WR > CTX_RD. CTX_WR beats CTX_RD so that a context save completes before a restore.
- Grants to requesters:
  - data_gnt_o = mem_gnt_i & (selected source is CORE).
  - ctx_wr_ready_o and ctx_rd_rq_ready_o are formed the same way for their sources.
- On each downstream grant, push the source ID into the owner FIFO.
- On each mem_rvalid_i, pop the FIFO head and route the response by owner:
  - CORE: data_rvalid_o=1, data_rdata_o=mem_rdata_i.
  - CTX_RD: ctx_rd_resp_valid_o=1, ctx_rd_data_o=mem_rdata_i.
  - CTX_WR: the response is consumed silently.
- mem_req_o is forced to 0 while the FIFO holds MAX_OUTSTANDING entries. A pop in the same cycle does not release this gate; the request goes out the next cycle.
- A push and a pop in the same cycle are both performed; the count is unchanged.
- mem_rvalid_i with an empty FIFO: ignored, and err_o is set. err_o clears only on reset.
- Reset, including mid-transaction: flush the FIFO, return to IDLE, drop any lock. Responses already in flight are not reissued.

## Timing
- Reset value of every output: 0.
- Request path: zero-cycle combinational from IDLE to mem_req_o. In a HOLD state, mem_req_o comes from the held source.
- Response path: zero-cycle combinational from mem_rvalid_i/mem_rdata_i to the routed output.
- Grant path: requester grant/ready outputs are combinational on mem_gnt_i.
- FIFO count, FSM state, starvation counter and err_o are registered.
- Throughput: one grant per cycle when mem_gnt_i is tied to 1 and the FIFO is not full.

## Configuration
- CTX_ARB_STARVE_EN defined:
  - A counter of width clog2(STARVE_LIMIT+1) increments each IDLE cycle in which CORE wins while CTX_WR or CTX_RD is pending.
  - The counter clears to 0 whenever a context source is granted, or when no context request is pending.
  - When the count reaches STARVE_LIMIT, context sources beat CORE in the next IDLE arbitration; CTX_WR still beats CTX_RD.
- CTX_ARB_STARVE_EN undefined: strict fixed priority CORE > CTX_WR > CTX_RD. No counter exists.

## Test plan
- Core only, mem_gnt_i=1, reads to 0x100 and 0x104 with rdata 0xAAAA0001 / 0xAAAA0002 returned one cycle later -> data_rvalid_o pulses with matching data. No ctx_* outputs toggle.
- CTX_WR 0x2000/0xDEADBEEF and CTX_RD 0x2004 asserted together, core idle -> write granted first, read next cycle. The write's rvalid is swallowed; the read's rdata 0x12345678 appears on ctx_rd_data_o.
- mem_gnt_i held 0 for 3 cycles on a CTX_RD request while data_req_i rises -> mem_addr_o stays 0x2004 until the grant. The core is granted the cycle after.
- MAX_OUTSTANDING=2, two grants with no rvalid -> mem_req_o=0 with data_req_i=1. After one rvalid, the request issues the following cycle.
- With CTX_ARB_STARVE_EN and STARVE_LIMIT=8, core requests continuously while CTX_WR is pending -> CTX_WR is granted at the 9th arbitration. Without the macro, CTX_WR is never granted.
- mem_rvalid_i with an empty FIFO -> err_o=1 and held. rst_ni asserted with 2 outstanding -> all outputs 0 and FIFO empty.

Source files
------------

// File: rtl/ctx_mem_arbiter_if.sv
// Bus bundle for the core OBI port, the RTOS context-save/restore ports and the downstream OBI memory port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface ctx_mem_arbiter_if;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;

    logic        ctx_wr_valid_i;
    logic [31:0] ctx_wr_addr_i;
    logic [31:0] ctx_wr_data_i;
    logic        ctx_wr_ready_o;
    logic        ctx_rd_rq_valid_i;
    logic [31:0] ctx_rd_rq_addr_i;
    logic        ctx_rd_rq_ready_o;
    logic        ctx_rd_resp_valid_o;
    logic [31:0] ctx_rd_data_o;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    logic        err_o;

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        input  ctx_wr_valid_i, ctx_wr_addr_i, ctx_wr_data_i,
        output ctx_wr_ready_o,
        input  ctx_rd_rq_valid_i, ctx_rd_rq_addr_i,
        output ctx_rd_rq_ready_o, ctx_rd_resp_valid_o, ctx_rd_data_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output err_o
    );

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        output ctx_wr_valid_i, ctx_wr_addr_i, ctx_wr_data_i,
        input  ctx_wr_ready_o,
        output ctx_rd_rq_valid_i, ctx_rd_rq_addr_i,
        input  ctx_rd_rq_ready_o, ctx_rd_resp_valid_o, ctx_rd_data_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  err_o
    );
endinterface

// File: rtl/ctx_mem_arbiter.sv
// Shares one OBI data-memory port between the core and the RTOS context save/restore traffic.
// Define CTX_ARB_STARVE_EN to let starved context traffic overtake the core after STARVE_LIMIT lost arbitrations.
module ctx_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    ctx_mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {SRC_NONE, SRC_CORE, SRC_WR, SRC_RD} src_e;
    typedef enum logic [1:0] {IDLE, HOLD_CORE, HOLD_WR, HOLD_RD} state_e;

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned DEPTH = 1 << PTR_W;

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
        $error("ctx_mem_arbiter: parameter out of range");
    end

    state_e             state_q, state_d;
    src_e               fifo_q [DEPTH];
    src_e               fifo_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;

    src_e               sel;
    src_e               head;
    logic               ctx_first;
    logic               ctx_pending;
    logic               sel_req;
    logic               req_out;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               mux_we;
    logic [3:0]         mux_be;
    logic [31:0]        mux_addr;
    logic [31:0]        mux_wdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign ctx_pending = bus.ctx_wr_valid_i | bus.ctx_rd_rq_valid_i;

`ifdef CTX_ARB_STARVE_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;
    assign ctx_first = (starve_q >= STARVE_W'(STARVE_LIMIT));
`else
    assign ctx_first = 1'b0;
`endif

    // A held source keeps the mux until its grant; otherwise pick the winner for this cycle.
    always_comb begin
        sel = SRC_NONE;
        case (state_q)
            HOLD_CORE: sel = SRC_CORE;
            HOLD_WR:   sel = SRC_WR;
            HOLD_RD:   sel = SRC_RD;
            default: begin
                if (ctx_first && bus.ctx_wr_valid_i)         sel = SRC_WR;
                else if (ctx_first && bus.ctx_rd_rq_valid_i) sel = SRC_RD;
                else if (bus.data_req_i)                     sel = SRC_CORE;
                else if (bus.ctx_wr_valid_i)                 sel = SRC_WR;
                else if (bus.ctx_rd_rq_valid_i)              sel = SRC_RD;
            end
        endcase
    end

    always_comb begin
        sel_req   = 1'b0;
        mux_we    = 1'b0;
        mux_be    = 4'h0;
        mux_addr  = 32'h0;
        mux_wdata = 32'h0;
        case (sel)
            SRC_CORE: begin
                sel_req   = bus.data_req_i;
                mux_we    = bus.data_we_i;
                mux_be    = bus.data_be_i;
                mux_addr  = bus.data_addr_i;
                mux_wdata = bus.data_wdata_i;
            end
            SRC_WR: begin
                sel_req   = bus.ctx_wr_valid_i;
                mux_we    = 1'b1;
                mux_be    = 4'hF;
                mux_addr  = bus.ctx_wr_addr_i;
                mux_wdata = bus.ctx_wr_data_i;
            end
            SRC_RD: begin
                sel_req   = bus.ctx_rd_rq_valid_i;
                mux_be    = 4'hF;
                mux_addr  = bus.ctx_rd_rq_addr_i;
            end
            default: ;
        endcase
    end

    // The full gate looks only at the registered count, so a same-cycle pop cannot release it.
    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign req_out    = sel_req & ~fifo_full;
    assign push       = req_out & bus.mem_gnt_i;
    assign pop        = bus.mem_rvalid_i & ~fifo_empty;
    assign head       = fifo_q[rd_ptr_q];

    assign bus.mem_req_o   = req_out;
    assign bus.mem_we_o    = mux_we;
    assign bus.mem_be_o    = mux_be;
    assign bus.mem_addr_o  = mux_addr;
    assign bus.mem_wdata_o = mux_wdata;

    assign bus.data_gnt_o        = push & (sel == SRC_CORE);
    assign bus.ctx_wr_ready_o    = push & (sel == SRC_WR);
    assign bus.ctx_rd_rq_ready_o = push & (sel == SRC_RD);

    // Context-write responses match neither route and are dropped here.
    assign bus.data_rvalid_o       = pop & (head == SRC_CORE);
    assign bus.data_rdata_o        = (pop && head == SRC_CORE) ? bus.mem_rdata_i : 32'h0;
    assign bus.ctx_rd_resp_valid_o = pop & (head == SRC_RD);
    assign bus.ctx_rd_data_o       = (pop && head == SRC_RD) ? bus.mem_rdata_i : 32'h0;
    assign bus.err_o               = err_q;

    always_comb begin
        state_d  = state_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q | (bus.mem_rvalid_i & fifo_empty);
        if (push) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        case (state_q)
            IDLE: begin
                if (req_out && !bus.mem_gnt_i) begin
                    case (sel)
                        SRC_CORE: state_d = HOLD_CORE;
                        SRC_WR:   state_d = HOLD_WR;
                        SRC_RD:   state_d = HOLD_RD;
                        default:  state_d = IDLE;
                    endcase
                end
            end
            default: begin
                if (push) state_d = IDLE;
            end
        endcase
`ifdef CTX_ARB_STARVE_EN
        starve_d = starve_q;
        if (!ctx_pending || (push && sel != SRC_CORE)) begin
            starve_d = '0;
        end else if (state_q == IDLE && sel == SRC_CORE && starve_q < STARVE_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STARVE_W'(1);
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= SRC_NONE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
`ifdef CTX_ARB_STARVE_EN
            starve_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
`ifdef CTX_ARB_STARVE_EN
            starve_q <= starve_d;
`endif
        end
    end

endmodule

// File: tb/tb_ctx_mem_arbiter.sv
// Self-checking bench for ctx_mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_ctx_mem_arbiter;

    localparam int MAX_OUT = 2;
    localparam int LIMIT   = 8;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    ctx_mem_arbiter_if bus();

    ctx_mem_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: sources are 1=core, 2=ctx write, 3=ctx read; owners lists unanswered grants in order.
    int owners[$];
    int m_held   = 0;
    int m_starve = 0;
    bit m_err    = 1'b0;

    bit g_granted;
    int g_src;

    logic        s_req, s_dgnt, s_wrrdy, s_rdrdy, s_drvalid, s_crvalid, s_err;
    logic [31:0] s_addr, s_wdata, s_drdata, s_crdata;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkFlag(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(
        input logic creq, input logic cwe, input logic [3:0] cbe, input logic [31:0] caddr, input logic [31:0] cwd,
        input logic wv, input logic [31:0] wa, input logic [31:0] wd,
        input logic rv, input logic [31:0] ra,
        input logic gnt, input logic mrv, input logic [31:0] mrd);
        bus.data_req_i        = creq;
        bus.data_we_i         = cwe;
        bus.data_be_i         = cbe;
        bus.data_addr_i       = caddr;
        bus.data_wdata_i      = cwd;
        bus.ctx_wr_valid_i    = wv;
        bus.ctx_wr_addr_i     = wa;
        bus.ctx_wr_data_i     = wd;
        bus.ctx_rd_rq_valid_i = rv;
        bus.ctx_rd_rq_addr_i  = ra;
        bus.mem_gnt_i         = gnt;
        bus.mem_rvalid_i      = mrv;
        bus.mem_rdata_i       = mrd;
    endtask

    task automatic applyIdle(input logic mrv, input logic [31:0] mrd);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 1, mrv, mrd);
    endtask

    function automatic bit srcValid(input int s);
        case (s)
            1:       return bus.data_req_i;
            2:       return bus.ctx_wr_valid_i;
            3:       return bus.ctx_rd_rq_valid_i;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int pickSource();
        bit ctx_first;
        ctx_first = 1'b0;
`ifdef CTX_ARB_STARVE_EN
        ctx_first = (m_starve >= LIMIT);
`endif
        if (m_held != 0) return m_held;
        if (ctx_first && bus.ctx_wr_valid_i)    return 2;
        if (ctx_first && bus.ctx_rd_rq_valid_i) return 3;
        if (bus.data_req_i)                     return 1;
        if (bus.ctx_wr_valid_i)                 return 2;
        if (bus.ctx_rd_rq_valid_i)              return 3;
        return 0;
    endfunction

    task automatic modelReset();
        owners.delete();
        m_held   = 0;
        m_starve = 0;
        m_err    = 1'b0;
    endtask

    // One clock: compare every output at the falling edge, then advance the model at the rising edge.
    task automatic runCycle();
        int          s, head;
        bit          full, req, granted, rv, ctx_pend;
        logic [31:0] ea, ewd;
        logic        ewe;
        logic [3:0]  ebe;
        @(negedge clk);
        s        = pickSource();
        full     = (owners.size() >= MAX_OUT);
        req      = (s != 0) && srcValid(s) && !full;
        granted  = req && bus.mem_gnt_i;
        rv       = bus.mem_rvalid_i;
        ctx_pend = bus.ctx_wr_valid_i || bus.ctx_rd_rq_valid_i;
        head     = (rv && owners.size() > 0) ? owners[0] : 0;

        s_req = bus.mem_req_o;   s_addr = bus.mem_addr_o;   s_wdata = bus.mem_wdata_o;
        s_dgnt = bus.data_gnt_o; s_wrrdy = bus.ctx_wr_ready_o; s_rdrdy = bus.ctx_rd_rq_ready_o;
        s_drvalid = bus.data_rvalid_o; s_drdata = bus.data_rdata_o;
        s_crvalid = bus.ctx_rd_resp_valid_o; s_crdata = bus.ctx_rd_data_o; s_err = bus.err_o;

        checkFlag("mem_req", bus.mem_req_o, req);
        if (req) begin
            case (s)
                1: begin ea = bus.data_addr_i; ewd = bus.data_wdata_i; ewe = bus.data_we_i; ebe = bus.data_be_i; end
                2: begin ea = bus.ctx_wr_addr_i; ewd = bus.ctx_wr_data_i; ewe = 1'b1; ebe = 4'hF; end
                default: begin ea = bus.ctx_rd_rq_addr_i; ewd = 32'h0; ewe = 1'b0; ebe = 4'hF; end
            endcase
            checkOutput("mem_addr", bus.mem_addr_o, ea);
            checkFlag("mem_we", bus.mem_we_o, ewe);
            checkOutput("mem_be", {28'h0, bus.mem_be_o}, {28'h0, ebe});
            if (s != 3) checkOutput("mem_wdata", bus.mem_wdata_o, ewd);
        end
        checkFlag("data_gnt", bus.data_gnt_o, granted && s == 1);
        checkFlag("ctx_wr_ready", bus.ctx_wr_ready_o, granted && s == 2);
        checkFlag("ctx_rd_rq_ready", bus.ctx_rd_rq_ready_o, granted && s == 3);
        checkFlag("data_rvalid", bus.data_rvalid_o, head == 1);
        if (head == 1) checkOutput("data_rdata", bus.data_rdata_o, bus.mem_rdata_i);
        checkFlag("ctx_rd_resp_valid", bus.ctx_rd_resp_valid_o, head == 3);
        if (head == 3) checkOutput("ctx_rd_data", bus.ctx_rd_data_o, bus.mem_rdata_i);
        checkFlag("err", bus.err_o, m_err);

        @(posedge clk);
`ifdef CTX_ARB_STARVE_EN
        if (!ctx_pend || (granted && s >= 2)) m_starve = 0;
        else if (m_held == 0 && s == 1 && m_starve < LIMIT) m_starve++;
`else
        if (ctx_pend) m_starve = 0;
`endif
        if (rv) begin
            if (owners.size() > 0) void'(owners.pop_front());
            else m_err = 1'b1;
        end
        if (granted) owners.push_back(s);
        if (granted) m_held = 0;
        else if (req && m_held == 0) m_held = s;
        g_granted = granted;
        g_src     = s;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && owners.size() > 0; i++) begin
            applyIdle(1'b1, $urandom);
            runCycle();
        end
        checkOutput("drain_empty", 32'(owners.size()), 32'h0);
    endtask

    task automatic checkAllZero(input string tag);
        checkFlag({tag, "_mem_req"}, bus.mem_req_o, 1'b0);
        checkFlag({tag, "_mem_we"}, bus.mem_we_o, 1'b0);
        checkOutput({tag, "_mem_be"}, {28'h0, bus.mem_be_o}, 32'h0);
        checkOutput({tag, "_mem_addr"}, bus.mem_addr_o, 32'h0);
        checkOutput({tag, "_mem_wdata"}, bus.mem_wdata_o, 32'h0);
        checkFlag({tag, "_data_gnt"}, bus.data_gnt_o, 1'b0);
        checkFlag({tag, "_data_rvalid"}, bus.data_rvalid_o, 1'b0);
        checkOutput({tag, "_data_rdata"}, bus.data_rdata_o, 32'h0);
        checkFlag({tag, "_ctx_wr_ready"}, bus.ctx_wr_ready_o, 1'b0);
        checkFlag({tag, "_ctx_rd_rq_ready"}, bus.ctx_rd_rq_ready_o, 1'b0);
        checkFlag({tag, "_ctx_rd_resp_valid"}, bus.ctx_rd_resp_valid_o, 1'b0);
        checkOutput({tag, "_ctx_rd_data"}, bus.ctx_rd_data_o, 32'h0);
        checkFlag({tag, "_err"}, bus.err_o, 1'b0);
    endtask

    initial begin
        bit          c_pend, w_pend, r_pend, c_we;
        logic [3:0]  c_be;
        logic [31:0] c_addr, c_wd, w_addr, w_data, r_addr;
        int          wr_grant_at;

        rst_ni = 1'b0;
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1;
        rst_ni = 1'b1;
        modelReset();

        $display("[TB] core-only reads");
        applyStimulus(1, 0, 4'hF, 32'h100, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
        runCycle();
        checkFlag("core_gnt_first", s_dgnt, 1'b1);
        applyStimulus(1, 0, 4'hF, 32'h104, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 1, 32'hAAAA0001);
        runCycle();
        checkOutput("core_rdata_1", s_drdata, 32'hAAAA0001);
        applyIdle(1'b1, 32'hAAAA0002);
        runCycle();
        checkOutput("core_rdata_2", s_drdata, 32'hAAAA0002);
        checkFlag("core_no_ctx_resp", s_crvalid, 1'b0);

        $display("[TB] context save then restore");
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h2000, 32'hDEADBEEF, 1, 32'h2004, 1, 0, 32'h0);
        runCycle();
        checkOutput("ctx_wr_addr", s_addr, 32'h2000);
        checkOutput("ctx_wr_wdata", s_wdata, 32'hDEADBEEF);
        checkFlag("ctx_rd_waits", s_rdrdy, 1'b0);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1, 32'h2004, 1, 1, 32'h55555555);
        runCycle();
        checkOutput("ctx_rd_addr", s_addr, 32'h2004);
        checkFlag("ctx_wr_resp_swallowed", s_crvalid | s_drvalid, 1'b0);
        applyIdle(1'b1, 32'h12345678);
        runCycle();
        checkOutput("ctx_rd_data_val", s_crdata, 32'h12345678);

        $display("[TB] held request");
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1, 32'h2004, 0, 0, 32'h0);
        runCycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 4'hF, 32'h100, 32'h0, 0, 32'h0, 32'h0, 1, 32'h2004, 0, 0, 32'h0);
            runCycle();
            checkOutput("hold_addr", s_addr, 32'h2004);
        end
        applyStimulus(1, 0, 4'hF, 32'h100, 32'h0, 0, 32'h0, 32'h0, 1, 32'h2004, 1, 0, 32'h0);
        runCycle();
        checkFlag("hold_rd_granted", s_rdrdy, 1'b1);
        applyStimulus(1, 0, 4'hF, 32'h100, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
        runCycle();
        checkFlag("hold_core_after", s_dgnt, 1'b1);
        drain();

        $display("[TB] outstanding limit");
        applyStimulus(1, 0, 4'hF, 32'h200, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
        runCycle();
        applyStimulus(1, 0, 4'hF, 32'h204, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
        runCycle();
        applyStimulus(1, 0, 4'hF, 32'h208, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
        runCycle();
        checkFlag("full_gate", s_req, 1'b0);
        applyStimulus(1, 0, 4'hF, 32'h208, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 1, 32'h11110000);
        runCycle();
        checkFlag("full_gate_same_pop", s_req, 1'b0);
        applyStimulus(1, 0, 4'hF, 32'h208, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
        runCycle();
        checkFlag("full_released", s_req, 1'b1);
        drain();

        $display("[TB] starvation");
        wr_grant_at = -1;
        w_pend = 1'b1;
        c_addr = 32'h500;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1, 0, 4'hF, c_addr, 32'h0, w_pend, 32'h3000, 32'hC0FFEE00, 0, 32'h0,
                          1, owners.size() > 0, $urandom);
            runCycle();
            if (g_granted && g_src == 1) c_addr = c_addr + 32'h4;
            if (g_granted && g_src == 2) begin
                w_pend = 1'b0;
                if (wr_grant_at < 0) wr_grant_at = i;
            end
        end
`ifdef CTX_ARB_STARVE_EN
        checkOutput("starve_grant_index", 32'(wr_grant_at), 32'd9);
`else
        checkOutput("starve_grant_index", 32'(wr_grant_at), 32'hFFFFFFFF);
`endif
        drain();

        $display("[TB] randomized traffic");
        c_pend = 0; w_pend = 0; r_pend = 0;
        c_we = 0; c_be = 4'h0; c_addr = 0; c_wd = 0; w_addr = 0; w_data = 0; r_addr = 0;
        for (int i = 0; i < 400; i++) begin
            if (!c_pend && $urandom_range(0, 2) == 0) begin
                c_pend = 1; c_we = 1'($urandom_range(0, 1)); c_be = 4'($urandom_range(1, 15));
                c_addr = $urandom & 32'hFFFF_FFFC; c_wd = $urandom;
            end
            if (!w_pend && $urandom_range(0, 3) == 0) begin
                w_pend = 1; w_addr = $urandom & 32'hFFFF_FFFC; w_data = $urandom;
            end
            if (!r_pend && $urandom_range(0, 3) == 0) begin
                r_pend = 1; r_addr = $urandom & 32'hFFFF_FFFC;
            end
            applyStimulus(c_pend, c_we, c_be, c_addr, c_wd, w_pend, w_addr, w_data, r_pend, r_addr,
                          $urandom_range(0, 3) != 0, owners.size() > 0 && $urandom_range(0, 1) == 1, $urandom);
            runCycle();
            if (g_granted) begin
                if (g_src == 1) c_pend = 0;
                if (g_src == 2) w_pend = 0;
                if (g_src == 3) r_pend = 0;
            end
        end
        for (int i = 0; i < 12 && (c_pend || w_pend || r_pend); i++) begin
            applyStimulus(c_pend, c_we, c_be, c_addr, c_wd, w_pend, w_addr, w_data, r_pend, r_addr,
                          1, owners.size() > 0, $urandom);
            runCycle();
            if (g_granted) begin
                if (g_src == 1) c_pend = 0;
                if (g_src == 2) w_pend = 0;
                if (g_src == 3) r_pend = 0;
            end
        end
        checkFlag("random_all_granted", c_pend | w_pend | r_pend, 1'b0);
        drain();

        $display("[TB] reset with outstanding, then orphan response");
        applyStimulus(1, 0, 4'hF, 32'h300, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
        runCycle();
        applyStimulus(1, 0, 4'hF, 32'h304, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
        runCycle();
        checkOutput("pre_reset_outstanding", 32'(owners.size()), 32'd2);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        rst_ni = 1'b0;
        #2;
        checkAllZero("midreset");
        modelReset();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        applyStimulus(1, 0, 4'hF, 32'h400, 32'h0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 0, 32'h0);
        runCycle();
        checkFlag("post_reset_req", s_req, 1'b1);
        applyIdle(1'b1, 32'hCAFE0001);
        runCycle();
        checkOutput("post_reset_rdata", s_drdata, 32'hCAFE0001);
        applyIdle(1'b1, 32'h00000BAD);
        runCycle();
        checkFlag("orphan_not_routed", s_drvalid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyIdle(1'b0, 32'h0);
            runCycle();
            checkFlag("err_sticky", s_err, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
